// File: rtl/sppf_pool_stream_pkg.sv
// Shared types, FP16 constants and ordering helpers for the SPPF pooling engine.
// Build option SPPF_ZERO_PAD_EN selects zero padding instead of -inf padding.
package sppf_pkg;

    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
    localparam logic [15:0] FP16_ZERO    = 16'h0000;

`ifdef SPPF_ZERO_PAD_EN
    localparam logic [15:0] PAD_VALUE = FP16_ZERO;
`else
    localparam logic [15:0] PAD_VALUE = FP16_NEG_INF;
`endif

    typedef enum logic [1:0] {
        LOAD,
        POOL,
        EMIT
    } state_t;

    // Map an FP16 pattern onto an unsigned key whose order matches numeric order
    // (bit 15 is the sign bit; +0 ranks above -0).
    function automatic logic [15:0] fp16_key(input logic [15:0] a);
        return a[15] ? ~a : (a ^ 16'h8000);
    endfunction

    // On equal keys the first argument wins, so callers pass the lower-index tap first.
    function automatic logic [15:0] fp16_max(input logic [15:0] a, input logic [15:0] b);
        return (fp16_key(b) > fp16_key(a)) ? b : a;
    endfunction

endpackage

// File: rtl/sppf_pool_stream_max_window.sv
// Combinational K-tap FP16 max reduction; taps outside the plane are replaced by the pad value.
module sppf_max_window
    import sppf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int K          = 5
) (
    input  logic [K*DATA_WIDTH-1:0] taps,
    input  logic [K-1:0]            mask,
    output logic [DATA_WIDTH-1:0]   win_max
);

    always_comb begin
        win_max = mask[0] ? taps[0 +: DATA_WIDTH] : PAD_VALUE;
        for (int j = 1; j < K; j++) begin
            win_max = fp16_max(win_max, mask[j] ? taps[j*DATA_WIDTH +: DATA_WIDTH] : PAD_VALUE);
        end
    end

endmodule

// File: rtl/sppf_pool_stream.sv
// Streaming cascaded K x K stride-1 FP16 max-pool (SPPF) emitting {x, m1, m2, m3} per element.
// Pad value comes from sppf_pkg and is switched by the SPPF_ZERO_PAD_EN build macro.
module sppf_pool_stream
    import sppf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int H          = 13,
    parameter int W          = 13,
    parameter int C          = 4,
    parameter int K          = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [0:DATA_WIDTH-1]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [0:4*DATA_WIDTH-1] out_data,
    output logic                    out_last,
    output logic                    busy
);

    localparam int P     = K / 2;
    localparam int NPIX  = H * W;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam int CH_W  = (C > 1) ? $clog2(C) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(W - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(C - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic [2:0]       stage, stage_nxt;
    logic [CH_W-1:0]  channel, channel_nxt;
    logic             load_we, pool_we;

    logic [DATA_WIDTH-1:0] p0  [NPIX];
    logic [DATA_WIDTH-1:0] p1  [NPIX];
    logic [DATA_WIDTH-1:0] p2  [NPIX];
    logic [DATA_WIDTH-1:0] p3  [NPIX];
    logic [DATA_WIDTH-1:0] tmp [NPIX];

    logic [K*DATA_WIDTH-1:0] taps;
    logic [K-1:0]            mask;
    logic [DATA_WIDTH-1:0]   win_max;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= LOAD;
            idx     <= '0;
            row     <= '0;
            col     <= '0;
            stage   <= '0;
            channel <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            row     <= row_nxt;
            col     <= col_nxt;
            stage   <= stage_nxt;
            channel <= channel_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        row_nxt     = row;
        col_nxt     = col;
        stage_nxt   = stage;
        channel_nxt = channel;
        load_we     = 1'b0;
        pool_we     = 1'b0;
        case (state)
            LOAD: begin
                if (in_valid) begin
                    load_we = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_nxt = POOL;
                        idx_nxt   = '0;
                        stage_nxt = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            POOL: begin
                pool_we = 1'b1;
                if (idx == LAST_IDX) begin
                    idx_nxt = '0;
                    row_nxt = '0;
                    col_nxt = '0;
                    if (stage == 3'd5) begin
                        state_nxt = EMIT;
                        stage_nxt = '0;
                    end else begin
                        stage_nxt = stage + 3'd1;
                    end
                end else begin
                    idx_nxt = idx + 1'b1;
                    if (col == LAST_COL) begin
                        col_nxt = '0;
                        row_nxt = row + 1'b1;
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt   = LOAD;
                        idx_nxt     = '0;
                        channel_nxt = (channel == LAST_CH) ? '0 : channel + 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == EMIT);
    assign busy      = (state != LOAD);
    assign out_last  = out_valid && (channel == LAST_CH) && (idx == LAST_IDX);
    assign out_data  = {p0[idx], p1[idx], p2[idx], p3[idx]};

    // Even stages slide the window along the row of Pk; odd stages slide it down the column of TMP.
    always_comb begin
        taps = '0;
        mask = '0;
        for (int j = 0; j < K; j++) begin
            int rr;
            int cc;
            logic [IDX_W-1:0] addr;
            rr   = int'(row) + (stage[0] ? (j - P) : 0);
            cc   = int'(col) + (stage[0] ? 0 : (j - P));
            addr = '0;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                mask[j] = 1'b1;
                addr    = IDX_W'(rr * W + cc);
            end
            case (stage)
                3'd0:    taps[j*DATA_WIDTH +: DATA_WIDTH] = p0[addr];
                3'd2:    taps[j*DATA_WIDTH +: DATA_WIDTH] = p1[addr];
                3'd4:    taps[j*DATA_WIDTH +: DATA_WIDTH] = p2[addr];
                default: taps[j*DATA_WIDTH +: DATA_WIDTH] = tmp[addr];
            endcase
        end
    end

    sppf_max_window #(
        .DATA_WIDTH(DATA_WIDTH),
        .K         (K)
    ) u_max_window (
        .taps   (taps),
        .mask   (mask),
        .win_max(win_max)
    );

    // Plane storage is deliberately left out of reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (load_we) begin
            p0[idx] <= in_data;
        end
        if (pool_we) begin
            case (stage)
                3'd1:    p1[idx]  <= win_max;
                3'd3:    p2[idx]  <= win_max;
                3'd5:    p3[idx]  <= win_max;
                default: tmp[idx] <= win_max;
            endcase
        end
    end

endmodule

// File: tb/tb_sppf_pool_stream.sv
// Directed self-checking bench for sppf_pool_stream on a 6x8 plane, two channels, K=5.
module tb_sppf_pool_stream;

    localparam int H    = 6;
    localparam int W    = 8;
    localparam int C    = 2;
    localparam int K    = 5;
    localparam int NPIX = H * W;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [0:15] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] out_data;
    logic        out_last;
    logic        busy;

    always #5 clk = ~clk;

    sppf_pool_stream #(
        .DATA_WIDTH(16),
        .H         (H),
        .W         (W),
        .C         (C),
        .K         (K)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_acc   = 0;
    int lat     = 0;

    logic [15:0] plane [NPIX];
    logic [63:0] beats [NPIX];
    logic        lasts [NPIX];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic fill_const(input logic [15:0] v);
        for (int i = 0; i < NPIX; i++) plane[i] = v;
    endtask

    task automatic fill_corner();
        fill_const(16'hBC00);
        plane[0] = 16'h4000;
    endtask

    task automatic fill_order();
        fill_const(16'hFC00);
        plane[0]         = 16'h8000;
        plane[1]         = 16'h0000;
        plane[2]         = 16'hC200;
        plane[3]         = 16'hC000;
        plane[3*W+0]     = 16'h8000;
        plane[5*W+6]     = 16'hC200;
        plane[5*W+7]     = 16'hC000;
    endtask

    // Feeds the plane; t_acc ends up as the cycle number of the last accepted element.
    task automatic load_plane();
        for (int i = 0; i < NPIX; i++) begin
            int g = 0;
            in_valid = 1'b1;
            in_data  = plane[i];
            @(negedge clk);
            while (!in_ready && g < 2000) begin
                @(negedge clk);
                g++;
            end
            if (!in_ready) begin
                chk("load_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        t_acc    = cyc - 1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit bp);
        int          k       = 0;
        int          g       = 0;
        int          ph      = 0;
        bit          stalled = 1'b0;
        bit          first   = 1'b1;
        logic [63:0] held_d  = '0;
        logic        held_l  = 1'b0;
        out_ready = 1'b1;
        while (k < NPIX && g < 5000) begin
            @(negedge clk);
            g++;
            if (out_valid) begin
                if (first) begin
                    lat   = cyc - t_acc;
                    first = 1'b0;
                end
                chk("in_ready_in_emit", 64'(in_ready), 64'd0);
                if (stalled) begin
                    chk("hold_data", out_data, held_d);
                    chk("hold_last", 64'(out_last), 64'(held_l));
                end
                if (out_ready) begin
                    beats[k] = out_data;
                    lasts[k] = out_last;
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = out_data;
                    held_l  = out_last;
                end
            end
            @(posedge clk);
            #1;
            if (bp && !first) begin
                ph++;
                out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
            end
        end
        out_ready = 1'b1;
        if (k < NPIX) chk("drain_timeout", 64'(k), 64'(NPIX));
        chk("in_ready_after", 64'(in_ready), 64'd1);
        chk("out_valid_after", 64'(out_valid), 64'd0);
    endtask

    function automatic logic [15:0] corner_lane(input int reach, input int r, input int c);
        return (r <= reach && c <= reach) ? 16'h4000 : 16'hBC00;
    endfunction

    function automatic logic [63:0] exp_corner(input int r, input int c);
        return {corner_lane(0, r, c), corner_lane(2, r, c), corner_lane(4, r, c), corner_lane(6, r, c)};
    endfunction

    task automatic chk_lasts(input string tag, input bit last_on_final);
        for (int i = 0; i < NPIX; i++)
            chk($sformatf("%s_last%0d", tag, i), 64'(lasts[i]), 64'(last_on_final && i == NPIX - 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;

        // Channel 0: constant plane, every lane equals the input.
        fill_const(16'h3C00);
        load_plane();
        @(negedge clk);
        chk("pool_busy", 64'(busy), 64'd1);
        chk("pool_in_ready", 64'(in_ready), 64'd0);
        chk("pool_out_valid", 64'(out_valid), 64'd0);
        drain(1'b0);
        chk("lat_const", 64'(lat), 64'(6 * NPIX + 1));
        for (int i = 0; i < NPIX; i++)
            chk($sformatf("const_beat%0d", i), beats[i], {4{16'h3C00}});
        chk_lasts("const", 1'b0);

        // Channel 1: single hot corner under backpressure; frame ends here.
        fill_corner();
        load_plane();
        drain(1'b1);
        chk("lat_corner", 64'(lat), 64'(6 * NPIX + 1));
        for (int i = 0; i < NPIX; i++)
            chk($sformatf("corner_x%0d", i), 64'(beats[i][63:48]), 64'(corner_lane(0, i / W, i % W)));
`ifdef SPPF_ZERO_PAD_EN
        chk("zp_m1_5_7", 64'(beats[5*W+7][47:32]), 64'h0000);
        chk("zp_m1_3_3", 64'(beats[3*W+3][47:32]), 64'hBC00);
`else
        for (int i = 0; i < NPIX; i++)
            chk($sformatf("corner_beat%0d", i), beats[i], exp_corner(i / W, i % W));
`endif
        chk_lasts("corner", 1'b1);

        // Channel wraps to 0: FP16 ordering with signed zeros and negatives.
        fill_order();
        load_plane();
        drain(1'b0);
        chk("ord_x_0_2", 64'(beats[2][63:48]), 64'hC200);
        chk("ord_m1_0_1", 64'(beats[1][47:32]), 64'h0000);
        chk("ord_m1_0_0", 64'(beats[0][47:32]), 64'h0000);
`ifndef SPPF_ZERO_PAD_EN
        chk("ord_m1_5_7", 64'(beats[5*W+7][47:32]), 64'hC000);
        chk("ord_m1_1_4", 64'(beats[1*W+4][47:32]), 64'hC000);
        chk("ord_m1_5_0", 64'(beats[5*W+0][47:32]), 64'h8000);
        chk("ord_m3_5_7", 64'(beats[5*W+7][15:0]), 64'h0000);
`endif
        chk_lasts("order", 1'b0);

        // Channel 1 interrupted by reset during stage 3; channel returns to 0.
        fill_corner();
        load_plane();
        repeat (3 * NPIX + 10) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        fill_corner();
        load_plane();
        drain(1'b0);
        chk("lat_after_rst", 64'(lat), 64'(6 * NPIX + 1));
        for (int i = 0; i < NPIX; i++)
            chk($sformatf("rst_x%0d", i), 64'(beats[i][63:48]), 64'(corner_lane(0, i / W, i % W)));
`ifndef SPPF_ZERO_PAD_EN
        for (int i = 0; i < NPIX; i++)
            chk($sformatf("rst_beat%0d", i), beats[i], exp_corner(i / W, i % W));
`endif
        chk_lasts("after_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
